// File: rtl/mux_2to1_arbiter.sv
// Round-robin arbiter driving the select of a shared 2:1 valid/ready mux.
// It holds a grant until end-of-packet or MAX_BURST beats, then hands over to the other side.
module mux_2to1_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;

    case (state_q)
      IDLE: begin
        // req0 wins unless req1 is also valid and holds the priority
        if (req0_valid && (!req1_valid || !prio_q)) begin
          state_d = GRANT0;
          sel_d   = 1'b0;
        end else if (req1_valid) begin
          state_d = GRANT1;
          sel_d   = 1'b1;
        end
      end

      GRANT0: begin
        out_valid  = req0_valid;
        out_data   = req0_data;
        out_last   = req0_last;
        req0_ready = out_ready;
        if (req0_valid && out_ready) begin
          if (req0_last || cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            prio_d = 1'b1;
            if (req1_valid) begin
              state_d = GRANT1;
              sel_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      GRANT1: begin
        out_valid  = req1_valid;
        out_data   = req1_data;
        out_last   = req1_last;
        req1_ready = out_ready;
        if (req1_valid && out_ready) begin
          if (req1_last || cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            prio_d = 1'b0;
            if (req0_valid) begin
              state_d = GRANT0;
              sel_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sel  = sel_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Directed bench for mux_2to1_arbiter (DATA_W=8, MAX_BURST=4).
// Inputs change 1ns after the rising edge; outputs are checked 4ns after it.
module tb_mux_2to1_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel, busy;

  int total = 0;
  int bad   = 0;

  mux_2to1_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .sel        (sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1,
                     input logic ordy);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    out_ready  = ordy;
    #3;
  endtask

  // Compares {sel,busy,out_valid,out_last,req0_ready,req1_ready,out_data} in one shot
  task automatic expect_o(input string tag, input logic s, input logic b, input logic v,
                          input logic l, input logic r0, input logic r1, input logic [7:0] d);
    logic [13:0] obs;
    logic [13:0] exp_v;
    obs   = {sel, busy, out_valid, out_last, req0_ready, req1_ready, out_data};
    exp_v = {s, b, v, l, r0, r1, d};
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (sel,busy,valid,last,r0,r1,data)", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drv(0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 8'h00, 0, 0, 8'h00, 0, 0);
    expect_o("reset_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    drv(1, 8'hA5, 1, 1, 8'h5A, 1, 1);
    expect_o("reset_masks_inputs", 0, 0, 0, 0, 0, 0, 8'h00);

    // single beat from req0
    @(posedge clk); #1; rst_n = 1'b1;
    drv(1, 8'hA5, 1, 0, 8'h00, 0, 1);
    expect_o("t1_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    drv(1, 8'hA5, 1, 0, 8'h00, 0, 1);
    expect_o("t1_grant0", 0, 1, 1, 1, 1, 0, 8'hA5);
    cyc();
    drv(1, 8'h11, 1, 1, 8'h22, 1, 1);
    expect_o("t1_back_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    drv(1, 8'h11, 1, 1, 8'h22, 1, 1);
    expect_o("t1_prio1_grant1", 1, 1, 1, 1, 0, 1, 8'h22);
    cyc();
    drv(1, 8'h11, 1, 1, 8'h22, 1, 1);
    expect_o("t1_zero_bubble_g0", 0, 1, 1, 1, 1, 0, 8'h11);

    // both valid, 2-beat packets
    do_reset();
    drv(1, 8'hA0, 0, 1, 8'hB0, 0, 1);
    expect_o("t2_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    drv(1, 8'hA0, 0, 1, 8'hB0, 0, 1);
    expect_o("t2_g0_beat1", 0, 1, 1, 0, 1, 0, 8'hA0);
    cyc();
    drv(1, 8'hA1, 1, 1, 8'hB0, 0, 1);
    expect_o("t2_g0_beat2", 0, 1, 1, 1, 1, 0, 8'hA1);
    cyc();
    drv(1, 8'hA2, 0, 1, 8'hB0, 0, 1);
    expect_o("t2_g1_beat1", 1, 1, 1, 0, 0, 1, 8'hB0);
    cyc();
    drv(1, 8'hA2, 0, 1, 8'hB1, 1, 1);
    expect_o("t2_g1_beat2", 1, 1, 1, 1, 0, 1, 8'hB1);
    cyc();
    drv(1, 8'hA2, 0, 0, 8'h00, 0, 1);
    expect_o("t2_back_to_g0", 0, 1, 1, 0, 1, 0, 8'hA2);

    // req1 6-beat packet split by MAX_BURST, req0 interleaves
    do_reset();
    drv(0, 8'h00, 0, 1, 8'hC1, 0, 1);
    expect_o("t3_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    for (int k = 1; k <= 4; k++) begin
      drv(1, 8'hD0, 1, 1, 8'hC0 + 8'(k), 0, 1);
      expect_o($sformatf("t3_g1_beat%0d", k), 1, 1, 1, 0, 0, 1, 8'hC0 + 8'(k));
      cyc();
    end
    drv(1, 8'hD0, 1, 1, 8'hC5, 0, 1);
    expect_o("t3_forced_to_g0", 0, 1, 1, 1, 1, 0, 8'hD0);
    cyc();
    drv(0, 8'h00, 0, 1, 8'hC5, 0, 1);
    expect_o("t3_resume_beat5", 1, 1, 1, 0, 0, 1, 8'hC5);
    cyc();
    drv(0, 8'h00, 0, 1, 8'hC6, 1, 1);
    expect_o("t3_resume_beat6", 1, 1, 1, 1, 0, 1, 8'hC6);
    cyc();
    drv(0, 8'h00, 0, 0, 8'h00, 0, 1);
    expect_o("t3_idle_after", 1, 0, 0, 0, 0, 0, 8'h00);

    // backpressure: stalls must not advance the beat count
    do_reset();
    drv(1, 8'hE0, 0, 0, 8'h00, 0, 0);
    expect_o("t4_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drv(1, 8'hE0, 0, 0, 8'h00, 0, 0);
      expect_o($sformatf("t4_stall%0d", k), 0, 1, 1, 0, 0, 0, 8'hE0);
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      drv(1, 8'hE0 + 8'(k), 0, 0, 8'h00, 0, 1);
      expect_o($sformatf("t4_beat%0d", k), 0, 1, 1, 0, 1, 0, 8'hE0 + 8'(k));
      cyc();
    end
    drv(1, 8'hE4, 0, 0, 8'h00, 0, 1);
    expect_o("t4_burst_release", 0, 0, 0, 0, 0, 0, 8'h00);

    // async reset in the middle of a req1 packet
    do_reset();
    drv(0, 8'h00, 0, 1, 8'hF0, 0, 1);
    expect_o("t5_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    drv(0, 8'h00, 0, 1, 8'hF0, 0, 1);
    expect_o("t5_beat1", 1, 1, 1, 0, 0, 1, 8'hF0);
    cyc();
    drv(0, 8'h00, 0, 1, 8'hF1, 0, 1);
    expect_o("t5_beat2", 1, 1, 1, 0, 0, 1, 8'hF1);
    rst_n = 1'b0;
    #1;
    expect_o("t5_async_reset", 0, 0, 0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(1, 8'h60, 1, 1, 8'h61, 1, 1);
    expect_o("t5_post_reset_idle", 0, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    drv(1, 8'h60, 1, 1, 8'h61, 1, 1);
    expect_o("t5_prio0_grant0", 0, 1, 1, 1, 1, 0, 8'h60);

    // req0 alone, back-to-back single-beat packets
    do_reset();
    drv(1, 8'h70, 1, 0, 8'h00, 0, 1);
    expect_o("t6_idle0", 0, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cyc();
      drv(1, 8'h70, 1, 0, 8'h00, 0, 1);
      expect_o($sformatf("t6_grant%0d", k), 0, 1, 1, 1, 1, 0, 8'h70);
      cyc();
      drv(1, 8'h70, 1, 0, 8'h00, 0, 1);
      expect_o($sformatf("t6_bubble%0d", k), 0, 0, 0, 0, 0, 0, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_2to1_arbiter.md
# mux_2to1_arbiter

Round-robin arbiter and sequencer for a shared 2:1 data multiplexer. Two requesters each present a valid/ready stream with an end-of-packet marker. The block owns the mux select, routes one requester at a time to a single valid/ready output, and holds the grant until the packet ends or a burst limit expires. It sits directly in front of the shared output resource that the 2:1 mux feeds.

## Interface
- DATA_W, 8, data width of each requester and of the output
- MAX_BURST, 4, maximum beats per grant before forced release (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester n has a beat
- req0_data / req1_data  in  DATA_W  requester n beat data
- req0_last / req1_last  in  1  beat is last of packet
- req0_ready / req1_ready  out  1  beat accepted from requester n
- out_valid  out  1  output beat present
- out_data  out  DATA_W  muxed data
- out_last  out  1  muxed last
- out_ready  in  1  downstream accepts beat
- sel  out  1  registered mux select (0 = req0, 1 = req1)
- busy  out  1  high while in a GRANT state

## Operation
- Registered state: FSM {IDLE, GRANT0, GRANT1}, sel, prio (requester preferred on the next tie), beat counter cnt (width clog2(MAX_BURST+1)).
- IDLE: all readies 0, out_valid 0, out_data 0, out_last 0.
  - One requester valid → grant it next cycle.
  - Both valid → grant the prio requester next cycle.
  - Neither valid → stay in IDLE.
- GRANTn: combinational pass-through.
  - out_valid = reqn_valid, out_data = reqn_data, out_last = reqn_last.
  - reqn_ready = out_ready; the other requester's ready = 0.
  - sel = n, busy = 1.
- Transfer = out_valid & out_ready. Each transfer increments cnt.
- Release occurs on a transfer where reqn_last = 1, or where cnt+1 == MAX_BURST, whichever comes first.
  - On release, prio ← other requester and cnt ← 0.
  - If the other requester's valid is high in the release cycle, the next state is GRANT(other); otherwise it is IDLE.
- Forced release mid-packet is permitted. The requester is re-granted later and resumes the packet. The downstream must tolerate interleaving at MAX_BURST boundaries.
- No transfer in GRANTn (valid low or out_ready low) → hold state, cnt unchanged. A requester dropping valid mid-packet does not release the grant.
- Input data is never registered. The block adds no storage beyond the FSM, sel, prio and cnt.

## Timing
- Reset (async assert, sync-safe deassert) values: state IDLE, sel 0, prio 0 (req0 preferred), cnt 0, busy 0, out_valid 0, out_data 0, out_last 0, req0_ready 0, req1_ready 0.
- Grant latency: valid seen in IDLE at cycle t → first beat can transfer at t+1.
- Release to a waiting requester: zero bubble. The last beat of A at cycle t is followed by the first beat of B at t+1.
- Release with no waiting requester: IDLE at t+1. A same-requester re-grant at t+2 gives one bubble cycle.
- Simultaneous release and new request from the releasing requester: the other requester wins if valid. Otherwise the block passes through IDLE.
- Reset asserted mid-packet: outputs drop to reset values immediately (asynchronous). The grant and partial count are discarded.
- MAX_BURST = 1: every beat releases and alternates between requesters when both are valid.

## Test plan
- Reset, then req0_valid=1, data 8'hA5, last=1, out_ready=1.
  - Required: at t+1, sel=0, out_data=A5, req0_ready=1, one transfer, then IDLE with prio=1.
- Both valid from reset, 2-beat packets (last on beat 2), out_ready=1.
  - Required: req0 granted first, both beats pass, then req1 granted with no bubble, then back to req0.
- req1 sends a 6-beat packet (last on beat 6) with MAX_BURST=4 and req0 also valid.
  - Required: req1's beats 1–4 pass, then req0 is granted, and req1 resumes beats 5–6 afterwards.
- GRANT0 with req0_valid=1 and out_ready held 0 for 3 cycles.
  - Required: out_valid=1, req0_ready=0, cnt unchanged, sel stable. The transfer completes in the cycle out_ready rises.
- rst_n pulled low during beat 2 of a req1 packet.
  - Required: out_valid, req1_ready and busy go 0 immediately. After release, with only req0 valid, req0 is granted 1 cycle later and prio=0.
- Only req0 valid and sending consecutive single-beat packets.
  - Required: the grant pattern is GRANT0, IDLE, GRANT0 … (one bubble each); req1 ready stays 0 throughout.
